score_scan_display: RTL and testbench
=====================================

Name: score_scan_display

Overview:
- Display-side consumer of the 14-bit binary score produced by the scoring logic.
- Converts the score sequentially to four BCD digits using an iterative double-dabble.
- Drives the shared, active-low 4-digit seven-segment display with time-multiplexed anodes, optional leading-zero blanking and blink gating.
- Sits between the scoring block and the board's seg/an pins; it replaces any combinational digit splitting on the display path.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit is lit (1 kHz per digit at 100 MHz); legal range 2 .. 2^20-1.
- SCORE_W, 14: score input width; the conversion runs SCORE_W shift iterations.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- btnR, input, 1: asynchronous, active-high reset.
- score, input, 14: unsigned binary score, sampled only on load.
- load, input, 1: single-cycle request to capture score and convert it.
- blank_zero, input, 1: 1 = blank leading-zero digits.
- blink_en, input, 1: 1 = blinking enabled.
- blink_phase, input, 1: blink square wave from the existing clock divider; while blink_en=1 and blink_phase=1, all anodes are off.
- seg, output, 7: cathodes, active-low; seg[0]=a .. seg[6]=g.
- an, output, 4: anodes, active-low; an[0] = ones digit, an[3] = thousands digit.
- busy, output, 1: conversion in progress.
- digits_valid, output, 1: one-cycle pulse when new digits are committed.

Behaviour:
- Reset (btnR=1, asynchronous, any state):
  - seg=7'h7F, an=4'hF, busy=0, digits_valid=0.
  - Digit registers d3..d0=0, scan index=0, refresh counter=0, pending=0, FSM=IDLE.
  - Any conversion in flight is aborted and its result is never committed.
- Capture and clamp: a captured value greater than 9999 is clamped to 9999 before conversion.
- FSM states:
  - IDLE: when load=1, capture the clamped score into the shift register, clear BCD, set iteration count=0, go to SHIFT. busy rises on the next edge.
  - SHIFT: once per cycle, first add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by one. After SCORE_W iterations (14 cycles), go to COMMIT.
  - COMMIT: copy the BCD nibbles to d3..d0, pulse digits_valid for this one cycle. If pending=1, reload from the pending value, clear pending and go to SHIFT; otherwise go to IDLE and drop busy.
- Latency: load at edge N produces digits_valid high during cycle N+15. New digits appear on seg no later than one refresh slot after that.
- load while busy: the clamped score is stored in a one-deep pending buffer and pending is set. A later load while busy overwrites the buffer, so the last value wins. load arriving in the same cycle as COMMIT is treated as pending.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the scan index increments mod 4 (3 wraps to 0).
  - an = ~(1 << index), registered, so outputs lag the index by one cycle.
- Segment encoding (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles 10-15 cannot occur; the decoder outputs all-off (1111111) for them.
- Blanking: with blank_zero=1, a digit is blanked (seg=1111111, anode still driven) when it and every higher digit are 0. d0 is never blanked, so a score of 0 shows a single "0".
- Blink: blink gating forces an=1111 only; scan timing and conversion continue unaffected.
- The displayed digits update only at COMMIT, never partially mid-conversion.

Decomposition:
- Shared package (slot_pkg):
  - The SEG_0..SEG_9 and SEG_OFF constants, also used by the reel display blocks.
  - SCORE_MAX=9999.
  - The FSM state encoding IDLE/SHIFT/COMMIT.
- One natural sub-module, bin2bcd_seq: the iterative double-dabble with load/busy/done. The top level holds the pending buffer, the digit registers and the scan/seg logic.

Test Plan:
- Reset then release, REFRESH_DIV=4, no load: an cycles 1110→1101→1011→0111 every 4 clocks; seg=1000000 on each digit (blank_zero=0).
- load with score=1234: busy=1 for 15 cycles, digits_valid pulses at N+15, d3..d0=1,2,3,4. Digit 0 shows 0011001 with an=1110; digit 3 shows 1111001 with an=0111.
- load with score=14'h3FFF (16383): digits are 9,9,9,9 (clamp).
- score=7, blank_zero=1: an=0111/1011/1101 slots show 1111111; an=1110 shows 1111000. With score=0, only the ones digit shows 1000000.
- load 500, then load 42 and load 88 while busy: exactly two digits_valid pulses; the final display reads 0088 (blank_zero=0).
- Assert btnR at SHIFT iteration 7 after load 9999: all outputs return to reset values immediately and no digits_valid pulse occurs. With blink_en=1 and blink_phase=1, an=1111 whatever the scan index.

Source files
------------

// File: rtl/slot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slot_pkg
// Brief    : Shared seven-segment codes, score limit and conversion FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package slot_pkg;

   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   localparam int SCORE_MAX = 9999;
   localparam int BCD_W     = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } conv_state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    seg_decode = SEG_0;
         4'd1:    seg_decode = SEG_1;
         4'd2:    seg_decode = SEG_2;
         4'd3:    seg_decode = SEG_3;
         4'd4:    seg_decode = SEG_4;
         4'd5:    seg_decode = SEG_5;
         4'd6:    seg_decode = SEG_6;
         4'd7:    seg_decode = SEG_7;
         4'd8:    seg_decode = SEG_8;
         4'd9:    seg_decode = SEG_9;
         default: seg_decode = SEG_OFF;
      endcase
   endfunction

   // Double-dabble correction applied before every shift.
   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
      dabble_adjust = bcd;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            dabble_adjust[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Iterative double-dabble, one shift per clock, with restart at commit.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
   import slot_pkg::*;
#(
   parameter int SCORE_W = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [SCORE_W-1:0] bin_in,
   output logic               busy,
   output logic               done,
   output logic [BCD_W-1:0]   bcd
);

   localparam int CNT_W = $clog2(SCORE_W + 1);
   localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(SCORE_W - 1);

   conv_state_t          r_state;
   conv_state_t          w_next;
   logic                 w_load;
   logic [SCORE_W-1:0]   r_bin;
   logic [BCD_W-1:0]     r_bcd;
   logic [CNT_W-1:0]     r_iter;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = SHIFT;
               w_load = 1'b1;
            end
         end
         SHIFT: begin
            if (r_iter == C_LAST_ITER)
               w_next = COMMIT;
         end
         COMMIT: begin
            // A start here chains the next conversion without an idle cycle.
            if (start) begin
               w_next = SHIFT;
               w_load = 1'b1;
            end else begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_iter <= '0;
      end else if (w_load) begin
         r_bin  <= bin_in;
         r_bcd  <= '0;
         r_iter <= '0;
      end else if (r_state == SHIFT) begin
         {r_bcd, r_bin} <= {dabble_adjust(r_bcd), r_bin} << 1;
         r_iter         <= r_iter + CNT_W'(1);
      end
   end

   assign busy = (r_state != IDLE);
   assign done = (r_state == COMMIT);
   assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/score_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : score_scan_display
// Brief    : Score to BCD conversion and multiplexed 4-digit 7-segment drive.
// Revision : 1.0 - initial release
// ============================================================================
module score_scan_display
   import slot_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int SCORE_W     = 14
) (
   input  logic               clk,
   input  logic               btnR,
   input  logic [SCORE_W-1:0] score,
   input  logic               load,
   input  logic               blank_zero,
   input  logic               blink_en,
   input  logic               blink_phase,
   output logic [6:0]         seg,
   output logic [3:0]         an,
   output logic               busy,
   output logic               digits_valid
);

   localparam int REF_W = 20;
   localparam logic [REF_W-1:0]   C_REF_LAST  = REF_W'(REFRESH_DIV - 1);
   localparam logic [SCORE_W-1:0] C_SCORE_MAX = SCORE_W'(SCORE_MAX);

   logic [SCORE_W-1:0] w_clamped;
   logic               w_eng_busy;
   logic               w_eng_done;
   logic [BCD_W-1:0]   w_eng_bcd;
   logic               w_start;
   logic [SCORE_W-1:0] w_start_val;

   logic               r_pending;
   logic [SCORE_W-1:0] r_pend_val;
   logic [BCD_W-1:0]   r_digits;
   logic [REF_W-1:0]   r_refresh;
   logic [1:0]         r_index;
   logic [6:0]         r_seg;
   logic [3:0]         r_an;

   logic [3:0]         w_nib;
   logic [3:0]         w_lead_zero;
   logic               w_blank;

   assign w_clamped = (score > C_SCORE_MAX) ? C_SCORE_MAX : score;

   // Start from a fresh load when idle, or drain the pending slot at commit/idle.
   assign w_start     = (!w_eng_busy && (load || r_pending)) || (w_eng_done && r_pending);
   assign w_start_val = (!w_eng_busy && load) ? w_clamped : r_pend_val;

   bin2bcd_seq #(
      .SCORE_W (SCORE_W)
   ) u_bin2bcd (
      .clk    (clk),
      .rst    (btnR),
      .start  (w_start),
      .bin_in (w_start_val),
      .busy   (w_eng_busy),
      .done   (w_eng_done),
      .bcd    (w_eng_bcd)
   );

   always_ff @(posedge clk or posedge btnR) begin
      if (btnR) begin
         r_pending  <= 1'b0;
         r_pend_val <= '0;
      end else if (load && w_eng_busy) begin
         r_pending  <= 1'b1;
         r_pend_val <= w_clamped;
      end else if (w_start) begin
         r_pending  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge btnR) begin
      if (btnR)
         r_digits <= '0;
      else if (w_eng_done)
         r_digits <= w_eng_bcd;
   end

   always_ff @(posedge clk or posedge btnR) begin
      if (btnR) begin
         r_refresh <= '0;
         r_index   <= 2'd0;
      end else if (r_refresh == C_REF_LAST) begin
         r_refresh <= '0;
         r_index   <= r_index + 2'd1;
      end else begin
         r_refresh <= r_refresh + REF_W'(1);
      end
   end

   // A digit is a leading zero when it and all higher digits are zero; d0 never is.
   assign w_lead_zero[3] = (r_digits[15:12] == 4'd0);
   assign w_lead_zero[2] = w_lead_zero[3] && (r_digits[11:8] == 4'd0);
   assign w_lead_zero[1] = w_lead_zero[2] && (r_digits[7:4] == 4'd0);
   assign w_lead_zero[0] = 1'b0;

   assign w_nib   = r_digits[{r_index, 2'b00} +: 4];
   assign w_blank = blank_zero && w_lead_zero[r_index];

   always_ff @(posedge clk or posedge btnR) begin
      if (btnR) begin
         r_seg <= SEG_OFF;
         r_an  <= 4'hF;
      end else begin
         r_seg <= w_blank ? SEG_OFF : seg_decode(w_nib);
         r_an  <= (blink_en && blink_phase) ? 4'hF : ~(4'b0001 << r_index);
      end
   end

   assign seg          = r_seg;
   assign an           = r_an;
   assign busy         = w_eng_busy | r_pending;
   assign digits_valid = w_eng_done;

endmodule
`default_nettype wire

// File: tb/tb_score_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_scan_display
// Brief    : Randomised scoreboard bench with a decimal-arithmetic display model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_scan_display;

   localparam int  RD = 4;
   localparam time P  = 10;

   logic        clk = 1'b0;
   logic        btnR = 1'b1;
   logic [13:0] score = '0;
   logic        load = 1'b0;
   logic        blank_zero = 1'b0;
   logic        blink_en = 1'b0;
   logic        blink_phase = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        busy;
   logic        digits_valid;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int  value;
      time t_exp;
   } exp_t;

   exp_t sb[$];

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   int p10 [4] = '{1, 10, 100, 1000};

   score_scan_display #(
      .REFRESH_DIV (RD),
      .SCORE_W     (14)
   ) dut (
      .clk          (clk),
      .btnR         (btnR),
      .score        (score),
      .load         (load),
      .blank_zero   (blank_zero),
      .blink_en     (blink_en),
      .blink_phase  (blink_phase),
      .seg          (seg),
      .an           (an),
      .busy         (busy),
      .digits_valid (digits_valid)
   );

   always #(P/2) clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampv(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   function automatic logic [6:0] exp_seg(input int val, input int i, input logic bz);
      if (bz && i > 0 && val < p10[i])
         return 7'h7F;
      return seg_tab[(val / p10[i]) % 10];
   endfunction

   initial begin : blink_gen
      forever begin
         repeat (3) @(negedge clk);
         blink_phase = ~blink_phase;
      end
   end

   // Monitor: scan/segment model from elapsed cycles, commits popped from the scoreboard.
   initial begin : monitor
      int         t;
      int         disp;
      int         stage;
      int         idx;
      logic [3:0] ean;
      exp_t       e;
      t = 0; disp = 0; stage = 0;
      forever begin
         @(posedge clk);
         #1;
         if (btnR) begin
            t = 0; disp = 0; stage = 0;
            sb.delete();
            check("reset_out", longint'({seg, an, busy, digits_valid}),
                  longint'({7'h7F, 4'hF, 1'b0, 1'b0}));
         end else begin
            t++;
            idx = ((t - 1) / RD) % 4;
            ean = (blink_en && blink_phase) ? 4'hF : ~(4'b0001 << idx);
            check("scan", longint'({an, seg}), longint'({ean, exp_seg(disp, idx, blank_zero)}));
            disp = stage;
            if (digits_valid) begin
               if (sb.size() == 0) begin
                  check("unexpected_valid", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("valid_time", longint'($time - 1), longint'(e.t_exp));
                  stage = e.value;
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int wd;
      wd = 0;
      while (busy !== 1'b0 && wd < 100) begin
         @(negedge clk);
         wd++;
      end
      if (wd >= 100)
         check("idle_timeout", 1, 0);
   endtask

   // One load while idle followed by n-1 loads while busy; the last of those wins.
   task automatic burst(input int vals[5], input int n, input logic bz, input logic blk);
      time t0;
      int  bcnt;
      wait_idle();
      @(negedge clk);
      blank_zero = bz;
      blink_en   = blk;
      load       = 1'b1;
      score      = 14'(vals[0]);
      @(posedge clk);
      t0 = $time;
      @(negedge clk);
      load = 1'b0;
      sb.push_back('{clampv(vals[0]), t0 + 14 * P});
      if (n == 1) begin
         bcnt = 0;
         for (int k = 0; k < 20; k++) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
         end
         check("busy_cycles", bcnt, 15);
      end else begin
         for (int k = 1; k < n; k++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            load  = 1'b1;
            score = 14'(vals[k]);
            @(negedge clk);
            load = 1'b0;
         end
         sb.push_back('{clampv(vals[n-1]), t0 + 29 * P});
      end
      wait_idle();
      repeat (4 * RD + 4) @(negedge clk);
   endtask

   function automatic int rand_score();
      case ($urandom_range(0, 3))
         0:       return $urandom_range(0, 9);
         1:       return $urandom_range(0, 999);
         2:       return $urandom_range(0, 9999);
         default: return $urandom_range(0, 16383);
      endcase
   endfunction

   initial begin : watchdog
      #(200000 * P);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int v[5];
      int n;
      repeat (3) @(negedge clk);
      btnR = 1'b0;
      repeat (20) @(negedge clk);

      burst('{1234, 0, 0, 0, 0}, 1, 1'b0, 1'b0);
      burst('{16383, 0, 0, 0, 0}, 1, 1'b0, 1'b0);
      burst('{7, 0, 0, 0, 0}, 1, 1'b1, 1'b0);
      burst('{0, 0, 0, 0, 0}, 1, 1'b1, 1'b0);
      burst('{500, 42, 88, 0, 0}, 3, 1'b0, 1'b0);
      burst('{10000, 305, 0, 0, 0}, 2, 1'b1, 1'b0);

      for (int r = 0; r < 30; r++) begin
         for (int k = 0; k < 5; k++) v[k] = rand_score();
         n = $urandom_range(1, 4);
         burst(v, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      end

      // Reset mid-conversion: after seven shift iterations of a 9999 load.
      wait_idle();
      @(negedge clk);
      blank_zero = 1'b0;
      blink_en   = 1'b1;
      load       = 1'b1;
      score      = 14'd9999;
      @(negedge clk);
      load = 1'b0;
      sb.push_back('{9999, $time + 14 * P});
      repeat (7) @(negedge clk);
      btnR = 1'b1;
      #1;
      check("async_reset", longint'({seg, an, busy, digits_valid}),
            longint'({7'h7F, 4'hF, 1'b0, 1'b0}));
      repeat (3) @(negedge clk);
      btnR = 1'b0;
      repeat (40) @(negedge clk);
      blink_en = 1'b0;
      repeat (20) @(negedge clk);

      check("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
